// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state encoding and ID-width helper for the round-robin bus arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANTED = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_e;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int arb_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: finds the first asserted request scanning from ptr upward, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is asserted.
module rr_priority_picker
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           rq,
    input  logic [arb_idw(N)-1:0]  ptr,
    output logic                   found,
    output logic [arb_idw(N)-1:0]  winner
);

    localparam int IDW = arb_idw(N);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;

    // Rotate so that the request at ptr lands on bit 0.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rot[i] = rq[IDW'((int'(ptr) + i) % N)];
        end
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
    end

    assign winner = IDW'((int'(ptr) + int'(off)) % N);

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin RQ/GRANT arbiter with a turnaround gap after each release.
// Latency: RQ sampled at edge k -> GRANT after edge k; re-grant gap is TURNAROUND_CYCLES+1 cycles.
// Backpressure: owner keeps the grant while its RQ stays high; ARB_TIMEOUT_EN enables forced preemption.
module bus_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_MASTERS       = 4,
    parameter int TURNAROUND_CYCLES = 1,
    parameter int MAX_HOLD_CYCLES   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS-1:0]          bus_rq,
    output logic [NUM_MASTERS-1:0]          bus_grant,
    output logic [arb_idw(NUM_MASTERS)-1:0] grant_id,
    output logic                            bus_busy,
    output logic                            timeout_pulse
);

    localparam int IDW = arb_idw(NUM_MASTERS);
    localparam int TW  = arb_idw(TURNAROUND_CYCLES);

    arb_state_e     state;
    logic [IDW-1:0] rr_ptr;
    logic [TW-1:0]  tcnt;
    logic           found;
    logic [IDW-1:0] winner;
    logic           owner_rq;
    logic           preempt;

    assign owner_rq = bus_rq[grant_id];

    rr_priority_picker #(
        .N (NUM_MASTERS)
    ) u_picker (
        .rq     (bus_rq),
        .ptr    (rr_ptr),
        .found  (found),
        .winner (winner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HW = arb_idw(MAX_HOLD_CYCLES);

    logic [HW-1:0] hcnt;

    // Saturates at the limit so a late competitor preempts on its first request cycle.
    assign preempt = (hcnt == HW'(MAX_HOLD_CYCLES - 1)) && (|(bus_rq & ~bus_grant));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt          <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= (state == ARB_GRANTED) && owner_rq && preempt;
            if (state != ARB_GRANTED) begin
                hcnt <= '0;
            end else if (hcnt != HW'(MAX_HOLD_CYCLES - 1)) begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end
`else
    assign preempt       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            bus_grant <= '0;
            grant_id  <= '0;
            bus_busy  <= 1'b0;
            rr_ptr    <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        bus_grant <= NUM_MASTERS'(1) << winner;
                        grant_id  <= winner;
                        rr_ptr    <= (winner == IDW'(NUM_MASTERS - 1)) ? '0 : winner + IDW'(1);
                        bus_busy  <= 1'b1;
                        state     <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (!owner_rq || preempt) begin
                        bus_grant <= '0;
                        grant_id  <= '0;
                        tcnt      <= '0;
                        state     <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    // Released drivers get TURNAROUND_CYCLES to go high-Z before the next owner.
                    if (tcnt == TW'(TURNAROUND_CYCLES - 1)) begin
                        bus_busy <= 1'b0;
                        state    <= ARB_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    bus_grant <= '0;
                    grant_id  <= '0;
                    bus_busy  <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scenarios plus random RQ traffic checked against a rule-level model.
// Honours ARB_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_bus_arbiter_rr;
    import arb_pkg::*;

    localparam int N   = 4;
    localparam int T   = 1;
    localparam int MH  = 8;
    localparam int IDW = arb_idw(N);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   bus_rq = '0;
    logic [N-1:0]   bus_grant;
    logic [IDW-1:0] grant_id;
    logic           bus_busy;
    logic           timeout_pulse;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_MASTERS       (N),
        .TURNAROUND_CYCLES (T),
        .MAX_HOLD_CYCLES   (MH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_rq        (bus_rq),
        .bus_grant     (bus_grant),
        .grant_id      (grant_id),
        .bus_busy      (bus_busy),
        .timeout_pulse (timeout_pulse)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner (-1 = none), remaining no-grant turnaround cycles, last owner, cycles held.
    int m_owner, m_gap, m_last, m_held;
    bit m_pulse;

    task automatic m_reset();
        m_owner = -1;
        m_gap   = 0;
        m_last  = N - 1;
        m_held  = 0;
        m_pulse = 0;
    endtask

    task automatic m_step(input logic [N-1:0] rq);
        m_pulse = 0;
        if (m_owner >= 0) begin
            if (!rq[m_owner]) begin
                m_owner = -1;
                m_gap   = T;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_held >= MH - 1 && (rq & ~(N'(1) << m_owner)) != '0) begin
                m_owner = -1;
                m_gap   = T;
                m_pulse = 1;
            end
`endif
            else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_last + 1 + k) % N;
                if (rq[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_held  = 0;
                    break;
                end
            end
        end
    endtask

    // Observed grant history: owner index at each new grant, no-grant cycles before it.
    int           order_q[$];
    int           gap_q[$];
    int           nog = -1;
    logic [N-1:0] prev_g = '0;

    task automatic clear_hist();
        order_q.delete();
        gap_q.delete();
        nog    = -1;
        prev_g = '0;
    endtask

    task automatic cycle(input logic [N-1:0] rq_next);
        logic [N-1:0] rs;
        @(negedge clk);
        bus_rq = rq_next;
        @(posedge clk);
        rs = bus_rq;
        m_step(rs);
        #1;
        chk("grant", 32'(bus_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("busy", 32'(bus_busy), 32'(m_owner >= 0 || m_gap > 0));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        chk("onehot0", 32'($onehot0(bus_grant)), 32'd1);
        chk("grant_without_rq", 32'(bus_grant & ~rs), 32'd0);
        if (bus_grant != '0 && prev_g == '0) begin
            if (nog >= 0) gap_q.push_back(nog);
            for (int i = 0; i < N; i++) if (bus_grant[i]) order_q.push_back(i);
        end
        if (bus_grant != '0) nog = 0;
        else if (nog >= 0) nog++;
        prev_g = bus_grant;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bus_rq = '1;
        m_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("reset_grant", 32'(bus_grant), 32'd0);
            chk("reset_busy", 32'(bus_busy), 32'd0);
            chk("reset_id", 32'(grant_id), 32'd0);
            chk("reset_pulse", 32'(timeout_pulse), 32'd0);
        end
        @(negedge clk);
        reset  = 1'b0;
        bus_rq = '0;
        clear_hist();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] nxt;
    int           hc;
    int           g1;
    int           pulses;
    bit           saw3;

    initial begin
        // Reset with all requests asserted
        do_reset();

        // Single request
        cycle(4'b0100);
        chk("single_grant", 32'(bus_grant), 32'h4);
        chk("single_id", 32'(grant_id), 32'd2);
        cycle(4'b0100);
        cycle(4'b0000);
        chk("single_release_grant", 32'(bus_grant), 32'd0);
        chk("single_release_busy", 32'(bus_busy), 32'd1);
        cycle(4'b0000);
        chk("single_idle_busy", 32'(bus_busy), 32'd0);

        // Fairness: all request; each owner drops RQ for one cycle after 3 granted cycles
        do_reset();
        nxt = '1;
        hc  = 0;
        for (int c = 0; c < 80 && order_q.size() < 5; c++) begin
            cycle(nxt);
            if (bus_grant != '0) hc++;
            else hc = 0;
            nxt = (hc == 3) ? ~bus_grant : 4'b1111;
        end
        chk("fair_count", 32'(order_q.size()), 32'd5);
        if (order_q.size() == 5) begin
            chk("fair_order0", 32'(order_q[0]), 32'd0);
            chk("fair_order1", 32'(order_q[1]), 32'd1);
            chk("fair_order2", 32'(order_q[2]), 32'd2);
            chk("fair_order3", 32'(order_q[3]), 32'd3);
            chk("fair_order4", 32'(order_q[4]), 32'd0);
            foreach (gap_q[i]) chk("fair_gap", 32'(gap_q[i]), 32'(T + 1));
        end

        // Simultaneous requests after master 2 served
        do_reset();
        repeat (3) cycle(4'b0100);
        repeat (2) cycle(4'b0000);
        clear_hist();
        repeat (3) cycle(4'b0101);
        for (int c = 0; c < 10 && order_q.size() < 2; c++) cycle(4'b0100);
        chk("simul_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            chk("simul_first", 32'(order_q[0]), 32'd0);
            chk("simul_second", 32'(order_q[1]), 32'd2);
        end

        // Master 1 holds, master 3 competes
        do_reset();
        cycle(4'b0010);
        g1     = (bus_grant == 4'b0010) ? 1 : 0;
        pulses = 0;
        saw3   = 0;
        for (int c = 0; c < 30 && !saw3; c++) begin
            cycle(4'b1010);
            if (bus_grant == 4'b0010) g1++;
            if (timeout_pulse) pulses++;
            if (bus_grant == 4'b1000) saw3 = 1;
        end
`ifdef ARB_TIMEOUT_EN
        chk("timeout_hold_cycles", 32'(g1), 32'(MH));
        chk("timeout_pulses", 32'(pulses), 32'd1);
        chk("timeout_next_owner", 32'(saw3), 32'd1);
`else
        chk("no_timeout_hold_cycles", 32'(g1), 32'd31);
        chk("no_timeout_pulses", 32'(pulses), 32'd0);
        chk("no_timeout_owner", 32'(bus_grant), 32'h2);
`endif

        // Asynchronous reset during an active grant
        chk("pre_reset_grant_active", 32'(bus_grant != '0), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_grant", 32'(bus_grant), 32'd0);
        chk("async_reset_busy", 32'(bus_busy), 32'd0);
        do_reset();

        // Random traffic, each RQ bit toggling with probability 1/4 per cycle
        for (int c = 0; c < 1500; c++) begin
            cycle(bus_rq ^ N'($urandom & $urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
